// File: rtl/branch_target_table.sv
// branch_target_table: multi-bank writable branch target lookup with valid bits, registered read, write-first bypass and bank clear
// Ports: Clk/Reset (async active-low); read port RdEn/RdBank/RdAddr -> RdTarget/RdValid one cycle later;
// write port WrEn/WrBank/WrAddr/WrData gated by WrReady; ClrReq/ClrBank start a bank sweep, Busy while sweeping.
// Optional macro BTT_STATS_EN adds saturating HitCnt/MissCnt read counters.
module branch_target_table #(
  parameter int ADDR_W = 5,
  parameter int TARGET_W = 10,
  parameter int BANKS = 4,
  localparam int BANK_W = $clog2(BANKS)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                RdEn,
  input  logic [BANK_W-1:0]   RdBank,
  input  logic [ADDR_W-1:0]   RdAddr,
  output logic [TARGET_W-1:0] RdTarget,
  output logic                RdValid,
  input  logic                WrEn,
  input  logic [BANK_W-1:0]   WrBank,
  input  logic [ADDR_W-1:0]   WrAddr,
  input  logic [TARGET_W-1:0] WrData,
  output logic                WrReady,
  input  logic                ClrReq,
  input  logic [BANK_W-1:0]   ClrBank,
`ifdef BTT_STATS_EN
  output logic [15:0]         HitCnt,
  output logic [15:0]         MissCnt,
`endif
  output logic                Busy
);
  localparam int ENTRIES = 2 ** ADDR_W;
  localparam int IDX_W = BANK_W + ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                state_q, state_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [BANKS*ENTRIES-1:0] valid_q, valid_d;
  logic [TARGET_W-1:0]   mem_q [BANKS*ENTRIES];
  logic [TARGET_W-1:0]   rd_target_q, rd_target_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [IDX_W-1:0]      rd_idx, wr_idx, clr_idx;
  logic                  wr_fire, bypass, blank, stored_hit;
  assign WrReady    = state_q == IDLE;
  assign Busy       = state_q == CLEAR;
  assign RdTarget   = rd_target_q;
  assign RdValid    = rd_valid_q;
  assign wr_fire    = WrEn && WrReady;
  assign rd_idx     = {RdBank, RdAddr};
  assign wr_idx     = {WrBank, WrAddr};
  assign clr_idx    = {bank_q, cnt_q[ADDR_W-1:0]};
  assign bypass     = wr_fire && wr_idx == rd_idx;
  // the whole bank under sweep reads as empty, not just the entries already cleared
  assign blank      = Busy && RdBank == bank_q;
  assign stored_hit = !blank && valid_q[rd_idx];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bank_d = bank_q;
    valid_d = valid_q;
    if (wr_fire) valid_d[wr_idx] = 1'b1;
    if (state_q == IDLE && ClrReq) begin
      state_d = CLEAR;
      cnt_d = '0;
      bank_d = ClrBank;
    end
    if (state_q == CLEAR) begin
      valid_d[clr_idx] = 1'b0;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == (ADDR_W+1)'(ENTRIES - 1)) state_d = IDLE;
    end
    rd_valid_d = RdEn ? (bypass || stored_hit) : rd_valid_q;
    rd_target_d = !RdEn ? rd_target_q : bypass ? WrData : stored_hit ? mem_q[rd_idx] : '0;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bank_q <= '0;
      valid_q <= '0;
      rd_target_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bank_q <= bank_d;
      valid_q <= valid_d;
      rd_target_q <= rd_target_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (wr_fire) mem_q[wr_idx] <= WrData;
  end
`ifdef BTT_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  assign HitCnt  = hit_cnt_q;
  assign MissCnt = miss_cnt_q;
  always_comb begin
    hit_cnt_d  = (RdEn && rd_valid_d && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 1'b1 : hit_cnt_q;
    miss_cnt_d = (RdEn && !rd_valid_d && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 1'b1 : miss_cnt_q;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif
endmodule
